// File: rtl/spi_sequencer.sv
// Replays a small table of SPI commands to an SPI master over the enable/busy
// handshake, captures each rx word, and supports periodic polling with a handshake timeout.
module spi_sequencer #(
  parameter int unsigned NUM_CMDS    = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned POLL_GAP    = 150000,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk_150MHz_i,
  input  logic              reset,
  input  logic              start,
  input  logic              poll_en,
  input  logic [IDX_W:0]    seq_len,
  input  logic [DIV_W-1:0]  clk_div_i,
  input  logic              cmd_we,
  input  logic [IDX_W-1:0]  cmd_wr_idx,
  input  logic [ADDR_W-1:0] cmd_wr_addr,
  input  logic [DATA_W-1:0] cmd_wr_data,
  input  logic              busy,
  input  logic [DATA_W-1:0] rx_data,
  output logic              enable,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] tx_data,
  output logic [DIV_W-1:0]  clk_div,
  output logic              rx_valid,
  output logic [IDX_W-1:0]  rx_idx,
  output logic [DATA_W-1:0] rx_word,
  output logic              seq_done,
  output logic              active,
  output logic              err_timeout
);

  // One down-counter serves both the poll gap and the handshake timeout.
  localparam int unsigned CNT_MAX = (POLL_GAP > TIMEOUT_CYC) ? POLL_GAP : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(POLL_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W:0]   LEN_MAX  = (IDX_W+1)'(NUM_CMDS);
  localparam logic [IDX_W:0]   LEN_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_NEXT,
    S_GAP,
    S_ABORT
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W:0]      len_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   tab_addr_q [NUM_CMDS];
  logic [DATA_W-1:0]   tab_data_q [NUM_CMDS];
  logic                enable_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   tx_q;
  logic [DIV_W-1:0]    clk_div_q;
  logic                rx_valid_q;
  logic [IDX_W-1:0]    rx_idx_q;
  logic [DATA_W-1:0]   rx_word_q;
  logic                seq_done_q;
  logic                err_q;

  logic len_ok;
  logic last_entry;

  assign len_ok     = (seq_len != '0) && (seq_len <= LEN_MAX);
  assign last_entry = ({1'b0, idx_q} == (len_q - LEN_ONE));

  always_ff @(posedge clk_150MHz_i or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      tab_addr_q <= '{default: '0};
      tab_data_q <= '{default: '0};
      enable_q   <= 1'b0;
      addr_q     <= '0;
      tx_q       <= '0;
      clk_div_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_idx_q   <= '0;
      rx_word_q  <= '0;
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      enable_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      seq_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cmd_we) begin
            tab_addr_q[cmd_wr_idx] <= cmd_wr_addr;
            tab_data_q[cmd_wr_idx] <= cmd_wr_data;
          end
          if ((start || poll_en) && len_ok) begin
            len_q     <= seq_len;
            clk_div_q <= clk_div_i;
            idx_q     <= '0;
            err_q     <= 1'b0;
            state_q   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          addr_q <= tab_addr_q[idx_q];
          tx_q   <= tab_data_q[idx_q];
          if (!busy) begin
            enable_q <= 1'b1;
            cnt_q    <= TO_LOAD;
            state_q  <= S_WAIT_BUSY;
          end
        end

        S_WAIT_BUSY: begin
          if (busy) begin
            cnt_q   <= TO_LOAD;
            state_q <= S_WAIT_DONE;
          end else if (cnt_q == '0) begin
            state_q <= S_ABORT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_WAIT_DONE: begin
          if (!busy) begin
            rx_word_q  <= rx_data;
            rx_idx_q   <= idx_q;
            rx_valid_q <= 1'b1;
            state_q    <= S_NEXT;
          end else if (cnt_q == '0) begin
            state_q <= S_ABORT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_NEXT: begin
          if (!last_entry) begin
            idx_q   <= idx_q + IDX_ONE;
            state_q <= S_ISSUE;
          end else begin
            seq_done_q <= 1'b1;
            if (poll_en) begin
              cnt_q   <= GAP_LOAD;
              state_q <= S_GAP;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        // Dropping poll_en here ends polling without waiting out the gap.
        S_GAP: begin
          if (!poll_en) begin
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            idx_q   <= '0;
            state_q <= S_ISSUE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_ABORT: begin
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign enable      = enable_q;
  assign addr        = addr_q;
  assign tx_data     = tx_q;
  assign clk_div     = clk_div_q;
  assign rx_valid    = rx_valid_q;
  assign rx_idx      = rx_idx_q;
  assign rx_word     = rx_word_q;
  assign seq_done    = seq_done_q;
  assign active      = (state_q != S_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_spi_sequencer.sv
// Self-checking bench for spi_sequencer: behavioural SPI master plus a
// command-table reference model, directed scenarios and randomized sequences.
module tb_spi_sequencer;

  localparam int NUM_CMDS    = 4;
  localparam int IDX_W       = 2;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 16;
  localparam int DIV_W       = 32;
  localparam int POLL_GAP    = 20;
  localparam int TIMEOUT_CYC = 16;

  logic              clk_150MHz_i = 1'b0;
  logic              reset;
  logic              start;
  logic              poll_en;
  logic [IDX_W:0]    seq_len;
  logic [DIV_W-1:0]  clk_div_i;
  logic              cmd_we;
  logic [IDX_W-1:0]  cmd_wr_idx;
  logic [ADDR_W-1:0] cmd_wr_addr;
  logic [DATA_W-1:0] cmd_wr_data;
  logic              busy;
  logic              busy_m;
  logic              busy_hold;
  logic [DATA_W-1:0] rx_data;
  logic              enable;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] tx_data;
  logic [DIV_W-1:0]  clk_div;
  logic              rx_valid;
  logic [IDX_W-1:0]  rx_idx;
  logic [DATA_W-1:0] rx_word;
  logic              seq_done;
  logic              active;
  logic              err_timeout;

  assign busy = busy_m | busy_hold;

  spi_sequencer #(
    .NUM_CMDS(NUM_CMDS), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .DIV_W(DIV_W), .POLL_GAP(POLL_GAP), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_150MHz_i(clk_150MHz_i), .reset(reset), .start(start), .poll_en(poll_en),
    .seq_len(seq_len), .clk_div_i(clk_div_i), .cmd_we(cmd_we), .cmd_wr_idx(cmd_wr_idx),
    .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data), .busy(busy), .rx_data(rx_data),
    .enable(enable), .addr(addr), .tx_data(tx_data), .clk_div(clk_div),
    .rx_valid(rx_valid), .rx_idx(rx_idx), .rx_word(rx_word), .seq_done(seq_done),
    .active(active), .err_timeout(err_timeout)
  );

  always #5 clk_150MHz_i = ~clk_150MHz_i;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  initial forever begin
    @(posedge clk_150MHz_i);
    cyc++;
  end

  // Reference model of the command table and expected latched divider
  logic [ADDR_W-1:0] tab_a [NUM_CMDS];
  logic [DATA_W-1:0] tab_d [NUM_CMDS];
  logic [DIV_W-1:0]  exp_div;

  // Behavioural SPI master
  int  lat_m     = 3;
  int  dur_m     = 10;
  bit  master_en = 1'b1;
  bit  rx_fixed  = 1'b0;
  int  rx_k      = 0;
  logic [DATA_W-1:0] rx_val;
  logic [DATA_W-1:0] mrx_q [$];
  int  fall_t [$];

  initial begin
    busy_m  = 1'b0;
    rx_data = '0;
    forever begin
      @(negedge clk_150MHz_i);
      if (!reset && enable === 1'b1 && master_en) begin
        for (int i = 0; i < lat_m; i++) begin
          @(negedge clk_150MHz_i);
          if (reset) break;
        end
        if (!reset) begin
          busy_m = 1'b1;
          for (int i = 0; i < dur_m; i++) begin
            @(negedge clk_150MHz_i);
            if (reset) break;
          end
          rx_val = rx_fixed ? DATA_W'(32'h00A0 + rx_k) : DATA_W'($urandom);
          rx_data = rx_val;
          busy_m = 1'b0;
          if (!reset) begin
            mrx_q.push_back(rx_val);
            fall_t.push_back(cyc);
            rx_k++;
          end
        end
      end
    end
  end

  // Output event monitor
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [31:0]       t;
  } en_rec_t;
  typedef struct packed {
    logic [IDX_W-1:0]  i;
    logic [DATA_W-1:0] w;
    logic [31:0]       t;
  } rx_rec_t;

  en_rec_t en_q [$];
  rx_rec_t rx_q [$];
  int      done_t [$];
  int      err_rise_t = -1;
  int      en_double  = 0;
  logic    en_prev    = 1'b0;
  logic    err_prev   = 1'b0;

  initial forever begin
    @(negedge clk_150MHz_i);
    if (enable === 1'b1) begin
      en_q.push_back('{a: addr, d: tx_data, t: cyc});
      if (en_prev) en_double++;
    end
    en_prev = enable;
    if (rx_valid === 1'b1) rx_q.push_back('{i: rx_idx, w: rx_word, t: cyc});
    if (seq_done === 1'b1) done_t.push_back(cyc);
    if (err_timeout === 1'b1 && !err_prev) err_rise_t = cyc;
    err_prev = err_timeout;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_150MHz_i);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    en_q.delete();
    rx_q.delete();
    done_t.delete();
    mrx_q.delete();
    fall_t.delete();
    err_rise_t = -1;
    en_double  = 0;
  endtask

  task automatic write_entry(input int i, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input bit apply);
    cmd_we      = 1'b1;
    cmd_wr_idx  = IDX_W'(i);
    cmd_wr_addr = a;
    cmd_wr_data = d;
    tick(1);
    cmd_we = 1'b0;
    if (apply) begin
      tab_a[i] = a;
      tab_d[i] = d;
    end
  endtask

  // Drives one start pulse; the divider input is scrambled afterwards so a
  // DUT that fails to latch it shows up in the clk_div check.
  task automatic launch(input int len, output int t0);
    seq_len   = (IDX_W+1)'(len);
    clk_div_i = $urandom;
    t0        = cyc;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    if (len >= 1 && len <= NUM_CMDS) exp_div = clk_div_i;
    clk_div_i = $urandom;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (active === 1'b1 && k < 1000) begin
      tick(1);
      k++;
    end
    check({tag, "_idle"}, 64'(active), 64'(0));
    tick(3);
  endtask

  task automatic check_seq(input string tag, input int len);
    check({tag, "_n_enable"}, 64'(en_q.size()), 64'(len));
    check({tag, "_n_rx"}, 64'(rx_q.size()), 64'(len));
    check({tag, "_n_done"}, 64'(done_t.size()), 64'(1));
    for (int k = 0; k < len; k++) begin
      if (k < en_q.size()) begin
        check($sformatf("%s_addr%0d", tag, k), 64'(en_q[k].a), 64'(tab_a[k]));
        check($sformatf("%s_tx%0d", tag, k), 64'(en_q[k].d), 64'(tab_d[k]));
      end
      if (k < rx_q.size() && k < mrx_q.size()) begin
        check($sformatf("%s_rx_idx%0d", tag, k), 64'(rx_q[k].i), 64'(k));
        check($sformatf("%s_rx_word%0d", tag, k), 64'(rx_q[k].w), 64'(mrx_q[k]));
      end
    end
    check({tag, "_err"}, 64'(err_timeout), 64'(0));
    check({tag, "_clk_div"}, 64'(clk_div), 64'(exp_div));
    check({tag, "_en_width"}, 64'(en_double), 64'(0));
    check({tag, "_addr_hold"}, 64'(addr), 64'(tab_a[len-1]));
    check({tag, "_tx_hold"}, 64'(tx_data), 64'(tab_d[len-1]));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_enable"}, 64'(enable), 64'(0));
    check({tag, "_addr"}, 64'(addr), 64'(0));
    check({tag, "_tx_data"}, 64'(tx_data), 64'(0));
    check({tag, "_clk_div"}, 64'(clk_div), 64'(0));
    check({tag, "_rx_valid"}, 64'(rx_valid), 64'(0));
    check({tag, "_rx_idx"}, 64'(rx_idx), 64'(0));
    check({tag, "_rx_word"}, 64'(rx_word), 64'(0));
    check({tag, "_seq_done"}, 64'(seq_done), 64'(0));
    check({tag, "_active"}, 64'(active), 64'(0));
    check({tag, "_err"}, 64'(err_timeout), 64'(0));
  endtask

  int t0;
  int r;
  int k;
  int nxt;
  int len;

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    poll_en     = 1'b0;
    seq_len     = '0;
    clk_div_i   = '0;
    cmd_we      = 1'b0;
    cmd_wr_idx  = '0;
    cmd_wr_addr = '0;
    cmd_wr_data = '0;
    busy_hold   = 1'b0;
    exp_div     = '0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      tab_a[i] = '0;
      tab_d[i] = '0;
    end
    tick(3);
    check_zero_outputs("reset");
    reset = 1'b0;
    tick(2);

    // Directed: four entries, fixed rx words A0..A3
    for (int i = 0; i < NUM_CMDS; i++)
      write_entry(i, ADDR_W'(i), DATA_W'(32'hF500 + i), 1'b1);
    lat_m = 3; dur_m = 10; rx_fixed = 1'b1; rx_k = 0;
    clear_mon();
    launch(4, t0);
    wait_idle("basic");
    check_seq("basic", 4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size())
        check($sformatf("basic_rx_const%0d", i), 64'(rx_q[i].w), 64'(32'h00A0 + i));
    if (en_q.size() > 0) check("basic_en_latency", 64'(int'(en_q[0].t) - t0), 64'(2));
    if (rx_q.size() > 0 && fall_t.size() > 0)
      check("basic_rx_latency", 64'(int'(rx_q[0].t) - fall_t[0]), 64'(1));
    rx_fixed = 1'b0;

    // Table write while active must be ignored
    lat_m = 1; dur_m = 3;
    clear_mon();
    launch(4, t0);
    k = 0;
    while (en_q.size() == 0 && k < 100) begin
      tick(1);
      k++;
    end
    write_entry(1, '1, 16'hFFFF, 1'b0);
    wait_idle("wr_active");
    check_seq("wr_active", 4);
    clear_mon();
    launch(4, t0);
    wait_idle("readback");
    check_seq("readback", 4);
    if (en_q.size() > 1) check("readback_entry1", 64'(en_q[1].d), 64'(16'hF501));

    // Out-of-range lengths never launch
    clear_mon();
    launch(0, t0);
    check("len0_active", 64'(active), 64'(0));
    tick(10);
    check("len0_no_enable", 64'(en_q.size()), 64'(0));
    launch(5, t0);
    check("len5_active", 64'(active), 64'(0));
    tick(10);
    check("len5_no_enable", 64'(en_q.size()), 64'(0));

    // Busy held by the master at launch withholds enable
    clear_mon();
    busy_hold = 1'b1;
    launch(3, t0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_no_enable%0d", i), 64'(enable), 64'(0));
      tick(1);
    end
    r = cyc;
    busy_hold = 1'b0;
    wait_idle("hold");
    check_seq("hold", 3);
    if (en_q.size() > 0) check("hold_release_latency", 64'(int'(en_q[0].t) - r), 64'(1));

    // Master never answers: timeout abort, then cleared by the next launch
    clear_mon();
    master_en = 1'b0;
    launch(2, t0);
    wait_idle("tmo");
    check("tmo_err", 64'(err_timeout), 64'(1));
    check("tmo_n_enable", 64'(en_q.size()), 64'(1));
    check("tmo_n_rx", 64'(rx_q.size()), 64'(0));
    check("tmo_n_done", 64'(done_t.size()), 64'(0));
    if (en_q.size() > 0)
      check("tmo_latency", 64'(err_rise_t - int'(en_q[0].t)), 64'(TIMEOUT_CYC + 1));
    master_en = 1'b1;
    clear_mon();
    launch(2, t0);
    check("tmo_cleared", 64'(err_timeout), 64'(0));
    wait_idle("after_tmo");
    check_seq("after_tmo", 2);

    // Polling with seq_len=2
    clear_mon();
    lat_m = 1; dur_m = 2;
    seq_len   = 3'd2;
    clk_div_i = $urandom;
    exp_div   = clk_div_i;
    poll_en   = 1'b1;
    tick(1);
    clk_div_i = $urandom;
    k = 0;
    while (done_t.size() < 3 && k < 2000) begin
      tick(1);
      k++;
    end
    check("poll_three_seqs", 64'(done_t.size() >= 3), 64'(1));
    for (int j = 0; j < 2; j++) begin
      nxt = -1;
      if (j < done_t.size()) begin
        for (int e = en_q.size() - 1; e >= 0; e--)
          if (int'(en_q[e].t) > done_t[j]) nxt = int'(en_q[e].t);
        check($sformatf("poll_gap%0d", j), 64'(nxt - done_t[j]), 64'(POLL_GAP + 1));
      end
    end
    k = 0;
    while (en_q.size() < 7 && k < 500) begin
      tick(1);
      k++;
    end
    poll_en = 1'b0;
    wait_idle("poll_stop");
    check("poll_n_enable", 64'(en_q.size()), 64'(8));
    check("poll_n_rx", 64'(rx_q.size()), 64'(8));
    check("poll_n_done", 64'(done_t.size()), 64'(4));
    check("poll_clk_div", 64'(clk_div), 64'(exp_div));
    for (int e = 0; e < en_q.size(); e++)
      check($sformatf("poll_addr%0d", e), 64'(en_q[e].a), 64'(tab_a[e % 2]));
    for (int e = 0; e < rx_q.size(); e++)
      if (e < mrx_q.size()) begin
        check($sformatf("poll_rx_idx%0d", e), 64'(rx_q[e].i), 64'(e % 2));
        check($sformatf("poll_rx_word%0d", e), 64'(rx_q[e].w), 64'(mrx_q[e]));
      end
    tick(POLL_GAP + 5);
    check("poll_stopped", 64'(en_q.size()), 64'(8));

    // Asynchronous reset in the middle of WAIT_DONE
    clear_mon();
    lat_m = 1; dur_m = 8;
    launch(4, t0);
    k = 0;
    while (busy_m !== 1'b1 && k < 100) begin
      tick(1);
      k++;
    end
    tick(2);
    check("rst_pre_active", 64'(active), 64'(1));
    #2 reset = 1'b1;
    #1 check_zero_outputs("async_rst");
    for (int i = 0; i < NUM_CMDS; i++) begin
      tab_a[i] = '0;
      tab_d[i] = '0;
    end
    tick(2);
    reset = 1'b0;
    tick(3);
    clear_mon();
    launch(4, t0);
    wait_idle("post_rst");
    check_seq("post_rst", 4);

    // Randomized tables, lengths and master timing
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NUM_CMDS; i++)
        write_entry(i, ADDR_W'($urandom), DATA_W'($urandom), 1'b1);
      len   = $urandom_range(1, NUM_CMDS);
      lat_m = $urandom_range(0, 4);
      dur_m = $urandom_range(1, 8);
      clear_mon();
      launch(len, t0);
      wait_idle($sformatf("rand%0d", it));
      check_seq($sformatf("rand%0d", it), len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
